// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-style Moore control FSM (optional JUMP_EN adds the jump state)
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       SignZero,
    output logic       PCEn,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
`ifdef JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    state_t     state_q, state_d;
    logic [2:0] alu_ctrl_q, alu_ctrl_d;
    logic       is_bne_q, is_bne_d;

    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       imm_ok;
    logic [2:0] imm_alu;
    logic       imm_signed;

    logic       pc_en_raw, ir_write_raw, reg_write_raw, mem_write_raw;

    // Decode the R-type function field into an ALU operation and a supported flag
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (Funct)
            6'b100000, 6'b100001: funct_alu = ALU_ADD;
            6'b100010, 6'b100011: funct_alu = ALU_SUB;
            6'b100100:            funct_alu = ALU_AND;
            6'b100101:            funct_alu = ALU_OR;
            6'b100110:            funct_alu = ALU_XOR;
            6'b100111:            funct_alu = ALU_NOR;
            6'b101010:            funct_alu = ALU_SLT;
            6'b101011:            funct_alu = ALU_SLTU;
            default:              funct_ok  = 1'b0;
        endcase
    end

    // Decode immediate-form opcodes into ALU operation and immediate extension mode
    always_comb begin
        imm_ok     = 1'b1;
        imm_alu    = ALU_ADD;
        imm_signed = 1'b0;
        case (Op)
            OP_ADDI:  begin imm_alu = ALU_ADD;  imm_signed = 1'b1; end
            OP_ADDIU: imm_alu = ALU_ADD;
            OP_SLTI:  begin imm_alu = ALU_SLT;  imm_signed = 1'b1; end
            OP_SLTIU: imm_alu = ALU_SLTU;
            OP_ANDI:  imm_alu = ALU_AND;
            OP_ORI:   imm_alu = ALU_OR;
            OP_XORI:  imm_alu = ALU_XOR;
            default:  imm_ok  = 1'b0;
        endcase
    end

    // Next-state logic and capture of per-instruction ALU op / branch sense in DECODE
    always_comb begin
        state_d    = S_FETCH;
        alu_ctrl_d = alu_ctrl_q;
        is_bne_d   = is_bne_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                alu_ctrl_d = (Op == OP_RTYPE) ? funct_alu : imm_alu;
                is_bne_d   = (Op == OP_BNE);
                if (Op == OP_LW || Op == OP_SW)        state_d = S_MEMADR;
                else if (Op == OP_RTYPE && funct_ok)   state_d = S_RTYPEEX;
                else if (Op == OP_BEQ || Op == OP_BNE) state_d = S_BRANCH;
                else if (imm_ok)                       state_d = S_IMMEX;
`ifdef JUMP_EN
                else if (Op == OP_J)                   state_d = S_JUMP;
`endif
                else                                   state_d = S_FETCH;
            end
            S_MEMADR:  state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_ALUWB;
            S_IMMEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // State and decoded-instruction registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            alu_ctrl_q <= ALU_ADD;
            is_bne_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_ctrl_q <= alu_ctrl_d;
            is_bne_q   <= is_bne_d;
        end
    end

    // Moore output decode; only the branch PC enable looks at Zero
    always_comb begin
        IorD          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        reg_write_raw = 1'b0;
        ALUSrcA       = 1'b0;
        SignZero      = 1'b0;
        pc_en_raw     = 1'b0;
        ALUSrcB       = 2'b00;
        PCSrc         = 2'b00;
        ALUControl    = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b01;
                pc_en_raw    = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                SignZero = 1'b1;
            end
            S_MEMRD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_RTYPEEX: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_ctrl_q;
            end
            S_ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                pc_en_raw  = is_bne_q ? ~Zero : Zero;
            end
            S_IMMEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = alu_ctrl_q;
                SignZero   = imm_signed;
            end
            S_IMMWB:  reg_write_raw = 1'b1;
`ifdef JUMP_EN
            S_JUMP: begin
                PCSrc     = 2'b10;
                pc_en_raw = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Architectural write strobes are held off for the whole reset interval
    assign PCEn     = pc_en_raw     & rst_n;
    assign IRWrite  = ir_write_raw  & rst_n;
    assign RegWrite = reg_write_raw & rst_n;
    assign MemWrite = mem_write_raw & rst_n;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, SignZero, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic [15:0] outs_vec;

    int checks;
    int failures;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .SignZero(SignZero),
        .PCEn(PCEn), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .State(State)
    );

    assign outs_vec = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, SignZero,
                       PCEn, ALUSrcB, PCSrc, ALUControl};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Instruction classes: 0 lw, 1 sw, 2 rtype, 3 branch, 4 imm, 5 jump, 6 unsupported
    function automatic int classify(input logic [5:0] op, input logic [5:0] funct);
        if (op == 6'b100011) return 0;
        if (op == 6'b101011) return 1;
        if (op == 6'b000000 && (funct inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                              6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                              6'b101010, 6'b101011})) return 2;
        if (op == 6'b000100 || op == 6'b000101) return 3;
        if (op >= 6'b001000 && op <= 6'b001110) return 4;
`ifdef JUMP_EN
        if (op == 6'b000010) return 5;
`endif
        return 6;
    endfunction

    function automatic int cycles_of(input int cls);
        int lat [7] = '{5, 4, 4, 3, 4, 3, 2};
        return lat[cls];
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] funct);
        logic [2:0] tbl [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        if (funct == 6'b101010) return 3'd6;
        if (funct == 6'b101011) return 3'd7;
        return tbl[funct[2:0]];
    endfunction

    function automatic logic [2:0] imm_op(input logic [5:0] op);
        logic [2:0] tbl [7] = '{3'd0, 3'd0, 3'd6, 3'd7, 3'd2, 3'd3, 3'd4};
        return tbl[op[2:0]];
    endfunction

    // Expected State and packed outputs for cycle 'step' of an instruction
    task automatic expect_cycle(input logic [5:0] op, input logic [5:0] funct, input int step,
                                input logic z, output logic [3:0] est, output logic [15:0] eo);
        int cls;
        logic iord, mw, irw, rd, m2r, rw, asa, sz, pce;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        int s2 [7] = '{2, 2, 6, 8, 9, 11, 0};
        int s3 [7] = '{3, 5, 7, 0, 10, 0, 0};
        cls = classify(op, funct);
        {iord, mw, irw, rd, m2r, rw, asa, sz, pce} = '0;
        asb = 2'b00; pcs = 2'b00; alu = 3'd0;
        est = 4'd0;
        if (step == 0) begin
            irw = 1; asb = 2'b01; pce = 1;
        end else if (step == 1) begin
            est = 4'd1; asb = 2'b11;
        end else if (step == 2) begin
            est = 4'(s2[cls]);
            case (cls)
                0, 1: begin asa = 1; asb = 2'b10; sz = 1; end
                2: begin asa = 1; alu = funct_op(funct); end
                3: begin asa = 1; alu = 3'd1; pcs = 2'b01; pce = (op == 6'b000101) ? ~z : z; end
                4: begin asa = 1; asb = 2'b10; alu = imm_op(op);
                         sz = (op == 6'b001000 || op == 6'b001010); end
                5: begin pcs = 2'b10; pce = 1; end
                default: ;
            endcase
        end else if (step == 3) begin
            est = 4'(s3[cls]);
            case (cls)
                0: iord = 1;
                1: begin iord = 1; mw = 1; end
                2: begin rd = 1; rw = 1; end
                4: rw = 1;
                default: ;
            endcase
        end else begin
            est = 4'd4; m2r = 1; rw = 1;
        end
        eo = {iord, mw, irw, rd, m2r, rw, asa, sz, pce, asb, pcs, alu};
    endtask

    // Runs one instruction from FETCH; entered and left at a falling edge with State=FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                             input int zmode, input int abort_step);
        logic [3:0]  est;
        logic [15:0] eo;
        int n;
        Op = op;
        Funct = funct;
        n = cycles_of(classify(op, funct));
        for (int s = 0; s < n; s++) begin
            Zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            expect_cycle(op, funct, s, Zero, est, eo);
            check_eq($sformatf("op%b_f%b_s%0d_state", op, funct, s), 32'(State), 32'(est));
            check_eq($sformatf("op%b_f%b_s%0d_outs", op, funct, s), 32'(outs_vec), 32'(eo));
            if (s == abort_step) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("abort_state", 32'(State), 32'd0);
                check_eq("abort_strobes", 32'({PCEn, IRWrite, RegWrite, MemWrite}), 32'd0);
                repeat (2) begin
                    @(negedge clk); #1;
                    check_eq("abort_hold_state", 32'(State), 32'd0);
                    check_eq("abort_hold_strobes", 32'({PCEn, IRWrite, RegWrite, MemWrite}), 32'd0);
                end
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    logic [5:0] op_pool [16] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b000101,
                                 6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101,
                                 6'b001110, 6'b000010, 6'b000000, 6'b111111};
    logic [5:0] funct_pool [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                    6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};

    initial begin
        logic [5:0] rop, rfn;
        checks = 0;
        failures = 0;
        Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_state", 32'(State), 32'd0);
        check_eq("reset_strobes", 32'({PCEn, IRWrite, RegWrite, MemWrite}), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_hold_state", 32'(State), 32'd0);
        check_eq("reset_hold_strobes", 32'({PCEn, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(6'b100011, 6'b000000, -1, -1);   // lw
        run_instr(6'b101011, 6'b000000, -1, -1);   // sw
        run_instr(6'b000000, 6'b100111, -1, -1);   // nor
        run_instr(6'b000101, 6'b000000, 0, -1);    // bne taken
        run_instr(6'b000101, 6'b000000, 1, -1);    // bne not taken
        run_instr(6'b000100, 6'b000000, 1, -1);    // beq taken
        run_instr(6'b000100, 6'b000000, 0, -1);    // beq not taken
        run_instr(6'b001100, 6'b000000, -1, -1);   // andi
        run_instr(6'b001010, 6'b000000, -1, -1);   // slti
        run_instr(6'b000000, 6'b000000, -1, -1);   // nop
        run_instr(6'b000010, 6'b000000, -1, -1);   // j
        run_instr(6'b101011, 6'b000000, -1, 3);    // sw aborted in MEMWR
        run_instr(6'b000000, 6'b000000, -1, -1);
        run_instr(6'b100011, 6'b000000, -1, 4);    // lw aborted in MEMWB
        run_instr(6'b000000, 6'b100001, -1, -1);

        for (int i = 0; i < 200; i++) begin
            rop = op_pool[$urandom_range(0, 15)];
            if (rop == 6'b111111) rop = 6'($urandom);
            rfn = ($urandom_range(0, 9) < 7) ? funct_pool[$urandom_range(0, 9)] : 6'($urandom);
            run_instr(rop, rfn, -1, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Op, input, 6 bits: instruction opcode, valid in every state after FETCH.
REQ-004 SHALL have port Funct, input, 6 bits: R-type function field.
REQ-005 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have 1-bit outputs IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, SignZero and PCEn: datapath strobes and selects.
REQ-007 SHALL have 2-bit outputs ALUSrcB and PCSrc: operand-B select and next-PC select.
REQ-008 SHALL have output ALUControl, 3 bits, encoded 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 sltu.
REQ-009 SHALL have output State, 4 bits: current state code, for debug.

Function
REQ-010 SHALL implement Moore FSM states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11.
REQ-011 SHALL drive all outputs to 0 in every state unless a requirement below sets them.
REQ-012 FETCH SHALL assert IRWrite=1, ALUSrcB=01, ALUControl=add and PCEn=1, then go to DECODE.
REQ-013 DECODE SHALL assert ALUSrcB=11 and ALUControl=add, then branch on Op:
- lw 100011 or sw 101011 -> MEMADR
- Op=000000 with supported Funct -> RTYPEEX
- beq 000100 or bne 000101 -> BRANCH
- addi, addiu, slti, sltiu, andi, ori, xori -> IMMEX
- anything else, including the all-zero nop -> FETCH
REQ-014 Supported Funct codes and their ALUControl: 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu.
REQ-015 The ALUControl value and the beq/bne flag for the current instruction SHALL be registered on the DECODE->next edge and held until the next FETCH.
REQ-016 MEMADR SHALL assert ALUSrcA=1, ALUSrcB=10, add and SignZero=1, then go to MEMRD for lw or MEMWR for sw.
REQ-017 MEMRD SHALL assert IorD=1, then go to MEMWB.
REQ-018 MEMWB SHALL assert MemtoReg=1 and RegWrite=1, then go to FETCH.
REQ-019 MEMWR SHALL assert IorD=1 and MemWrite=1, then go to FETCH.
REQ-020 RTYPEEX SHALL assert ALUSrcA=1, ALUSrcB=00 and the registered ALUControl, then go to ALUWB.
REQ-021 ALUWB SHALL assert RegDst=1 and RegWrite=1, then go to FETCH.
REQ-022 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, sub and PCSrc=01, then go to FETCH.
- PCEn (combinational) = Zero for beq, ~Zero for bne.
REQ-023 IMMEX SHALL assert ALUSrcA=1, ALUSrcB=10 and the per-op ALUControl and SignZero, then go to IMMWB:
- addi: add, SignZero=1
- addiu: add, SignZero=0
- slti: slt, SignZero=1
- sltiu: sltu, SignZero=0
- andi: and, SignZero=0
- ori: or, SignZero=0
- xori: xor, SignZero=0
REQ-024 IMMWB SHALL assert RegWrite=1 with RegDst=0, then go to FETCH.
REQ-025 Latency SHALL be 5 cycles for lw, 4 for sw, R-type and immediate ops, 3 for branches, and 2 for nop/unsupported instructions.

Reset
REQ-026 While rst_n=0, State SHALL be FETCH and the registered ALUControl and beq/bne flag SHALL be 0, independent of clk.
REQ-027 During reset, the FETCH-state output values SHALL NOT take effect: PCEn, IRWrite, RegWrite and MemWrite SHALL be forced to 0 while rst_n=0.
REQ-028 Reset asserted mid-instruction SHALL abort the instruction with no further register or memory write; after release the first rising edge executes FETCH.

Configuration
REQ-029 With JUMP_EN defined, Op 000010 in DECODE SHALL go to JUMP; JUMP asserts PCSrc=10 and PCEn=1, then goes to FETCH.
REQ-030 Without JUMP_EN, Op 000010 SHALL be treated as unsupported (DECODE->FETCH) and PCSrc SHALL never equal 10.

Verification
REQ-031 lw (Op=100011): release reset -> State sequence 0,1,2,3,4,0, with RegWrite=1 and MemtoReg=1 only in state 4.
REQ-032 Op=000000, Funct=100111 -> ALUControl=101 in RTYPEEX; RegDst=1 and RegWrite=1 in ALUWB.
REQ-033 bne with Zero=0 -> PCEn=1 and PCSrc=01 in BRANCH; the same with Zero=1 -> PCEn=0.
REQ-034 andi -> SignZero=0 and ALUControl=010 in IMMEX; slti -> SignZero=1 and ALUControl=110.
REQ-035 Reset dropped during MEMWR -> MemWrite falls to 0 immediately, State=0, and no write occurs after release.
REQ-036 Op=000010 -> State 0,1,11,0 with PCSrc=10 when JUMP_EN is defined; State 0,1,0 when it is not.
